// File: rtl/sparc_pkg.sv
// Shared SPARC pipeline constants.
// Used by fetch, the instruction ROM and decode.
package sparc_pkg;

  localparam int ADDR_W = 9;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0100_0000;

endpackage

// File: rtl/sparc_fetch_unit.sv
// SPARC instruction-fetch stage.
// Holds the PC/nPC pair, drives the ROM address and captures the IF/ID word.
module sparc_fetch_unit
  import sparc_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter logic [ADDR_W_P-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_W = NOP_WORD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W_P-1:0] branch_target,
  input  logic                annul,
  output logic [ADDR_W_P-1:0] rom_addr,
  input  logic [INSTR_W-1:0]  rom_instr,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic [ADDR_W_P-1:0] ifid_pc,
  output logic                ifid_valid,
  output logic [31:0]         fetch_count
);

  localparam logic [ADDR_W_P-1:0] STEP = ADDR_W_P'(4);

  logic [ADDR_W_P-1:0] pc;
  logic [ADDR_W_P-1:0] npc;
  logic [ADDR_W_P-1:0] target;
  logic [ADDR_W_P-1:0] pc_next;
  logic [ADDR_W_P-1:0] npc_next;

  assign rom_addr = pc;

  // Next PC/nPC: a taken branch redirects, otherwise advance along nPC.
  always_comb begin
    target = {branch_target[ADDR_W_P-1:2], 2'b00};
    pc_next = npc;
    npc_next = npc + STEP;
    if (branch_taken) begin
      pc_next = target;
      npc_next = target + STEP;
    end
  end

  // PC/nPC and IF/ID registers; the capture at old pc is the delay slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      npc <= RESET_PC + STEP;
      ifid_instr <= NOP_W;
      ifid_pc <= '0;
      ifid_valid <= 1'b0;
      fetch_count <= '0;
    end else if (!stall) begin
      pc <= pc_next;
      npc <= npc_next;
      ifid_pc <= pc;
      if (annul) begin
        ifid_instr <= NOP_W;
        ifid_valid <= 1'b0;
      end else begin
        ifid_instr <= rom_instr;
        ifid_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_sparc_fetch_unit.sv
// Self-checking bench for sparc_fetch_unit.
// Byte ROM plus a plain-arithmetic fetch model.
module tb_sparc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [8:0]  branch_target;
  logic        annul;
  logic [8:0]  rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] ifid_instr;
  logic [8:0]  ifid_pc;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  logic [7:0] mem [0:511];

  int total = 0;
  int bad = 0;

  int m_pc, m_npc, m_ipc, m_valid;
  logic [31:0] m_instr, m_cnt;

  always #5 clk = ~clk;

  sparc_fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .annul(annul),
    .rom_addr(rom_addr),
    .rom_instr(rom_instr),
    .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid),
    .fetch_count(fetch_count)
  );

  always_comb begin
    rom_instr = {mem[int'(rom_addr)], mem[int'(rom_addr) + 1],
                 mem[int'(rom_addr) + 2], mem[int'(rom_addr) + 3]};
  end

  function automatic logic [31:0] word(int a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".rom_addr"}, 32'(rom_addr), 32'(m_pc));
    check({tag, ".ifid_pc"}, 32'(ifid_pc), 32'(m_ipc));
    check({tag, ".ifid_instr"}, ifid_instr, m_instr);
    check({tag, ".ifid_valid"}, 32'(ifid_valid), 32'(m_valid));
    check({tag, ".fetch_count"}, fetch_count, m_cnt);
  endtask

  task automatic cyc(input logic r, input logic s, input logic b,
                     input int t, input logic a);
    rst_n = r;
    stall = s;
    branch_taken = b;
    branch_target = 9'(t);
    annul = a;
    if (!r) begin
      m_pc = 0;
      m_npc = 4;
      m_ipc = 0;
      m_instr = 32'h0100_0000;
      m_valid = 0;
      m_cnt = 0;
    end else if (!s) begin
      m_ipc = m_pc;
      if (a) begin
        m_instr = 32'h0100_0000;
        m_valid = 0;
      end else begin
        m_instr = word(m_pc);
        m_valid = 1;
        m_cnt = m_cnt + 1;
      end
      if (b) begin
        m_pc = (t / 4) * 4;
        m_npc = (m_pc + 4) % 512;
      end else begin
        m_pc = m_npc;
        m_npc = (m_npc + 4) % 512;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++)
      mem[i] = (i < 16) ? 8'(i) : 8'($urandom_range(255));
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    annul = 1'b0;
    m_pc = 0; m_npc = 4; m_ipc = 0; m_valid = 0;
    m_instr = 32'h0100_0000; m_cnt = 0;

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_all("reset");
    check("reset.nop", ifid_instr, 32'h0100_0000);

    cyc(1, 0, 0, 0, 0);
    check_all("run0");
    check("run0.word", ifid_instr, 32'h0001_0203);
    cyc(1, 0, 0, 0, 0);
    check_all("run1");
    check("run1.word", ifid_instr, 32'h0405_0607);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 'h100, 1);
      check_all("stall");
      check("stall.addr", 32'(rom_addr), 32'h8);
      check("stall.cnt", fetch_count, 32'd2);
    end

    cyc(1, 0, 0, 0, 0);
    check_all("resume");
    check("resume.word", ifid_instr, 32'h0809_0A0B);

    cyc(1, 0, 1, 'h40, 0);
    check_all("br.slot");
    check("br.slot.word", ifid_instr, 32'h0C0D_0E0F);
    check("br.slot.cnt", fetch_count, 32'd4);
    cyc(1, 0, 0, 0, 0);
    check_all("br.t0");
    check("br.t0.pc", 32'(ifid_pc), 32'h40);
    cyc(1, 0, 0, 0, 0);
    check_all("br.t1");

    cyc(1, 0, 1, 'h20, 0);
    check_all("to20");
    cyc(1, 0, 1, 'h83, 1);
    check_all("annul");
    check("annul.pc", 32'(ifid_pc), 32'h20);
    check("annul.valid", 32'(ifid_valid), 32'd0);
    cyc(1, 0, 0, 0, 0);
    check_all("aligned");
    check("aligned.pc", 32'(ifid_pc), 32'h80);

    cyc(1, 0, 1, 'h1F8, 0);
    check("wrap.0", 32'(rom_addr), 32'h1F8);
    cyc(1, 0, 0, 0, 0);
    check("wrap.1", 32'(rom_addr), 32'h1FC);
    cyc(1, 0, 0, 0, 0);
    check("wrap.2", 32'(rom_addr), 32'h000);
    check_all("wrap.2m");
    cyc(1, 0, 0, 0, 0);
    check("wrap.3", 32'(rom_addr), 32'h004);

    for (int i = 0; i < 300; i++) begin
      cyc(1, ($urandom_range(3) == 0), ($urandom_range(4) == 0),
          int'($urandom_range(511)), ($urandom_range(5) == 0));
      check_all("rand");
    end

    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 'h44, 0);
    check_all("rst.mid");
    check("rst.mid.pc", 32'(rom_addr), 32'h0);
    check("rst.mid.cnt", fetch_count, 32'd0);
    cyc(1, 0, 0, 0, 0);
    check_all("rst.first");
    check("rst.first.valid", 32'(ifid_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sparc_fetch_unit.md
Name: sparc_fetch_unit

Overview:
- Instruction-fetch stage of the SPARC pipeline. Holds the PC/nPC pair and drives the byte address of the instruction ROM.
- Captures the ROM's 32-bit big-endian instruction word into the IF/ID register.
- Applies stall and the delayed-branch redirect with annul, both driven by the decode stage.
- Sits directly upstream of the instruction ROM (drives its address) and directly downstream of it (consumes its word).

Parameters:
- ADDR_W, 9, byte-address width; matches the ROM address port.
- RESET_PC, 0, PC value after reset; must be word aligned.
- NOP_WORD, 32'h0100_0000, SPARC nop (sethi 0,%g0); loaded into IF/ID on reset and on annul.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hold PC, nPC and IF/ID.
- branch_taken  in  1  decode-stage redirect (CTI in ID is taken).
- branch_target  in  ADDR_W  redirect byte address; bits[1:0] ignored.
- annul  in  1  squash the delay-slot word being captured this cycle.
- rom_addr  out  ADDR_W  byte address to the ROM; always equals pc.
- rom_instr  in  32  ROM word for rom_addr; combinational, same cycle.
- ifid_instr  out  32  registered instruction to decode.
- ifid_pc  out  ADDR_W  address of ifid_instr.
- ifid_valid  out  1  ifid_instr is a real (non-annulled) instruction.
- fetch_count  out  32  number of valid captures, for debug.

Behaviour:
- Reset (rst_n=0 at a rising edge, overrides all other inputs):
  - pc<=RESET_PC, npc<=RESET_PC+4.
  - ifid_instr<=NOP_WORD, ifid_pc<=0, ifid_valid<=0, fetch_count<=0.
  - Reset asserted mid-stall or mid-redirect discards all pending state.
- rom_addr=pc, combinationally. Fetch latency is one cycle: the word at pc appears on ifid_instr at the next edge.
- Register update priority per edge: reset > stall > branch_taken > sequential.
- stall=1: pc, npc, ifid_* and fetch_count all hold. branch_taken and annul are ignored, because decode re-presents them while it is stalled.
- Sequential update (stall=0, branch_taken=0): pc<=npc, npc<=npc+4.
- Taken branch (stall=0, branch_taken=1): pc<=target, npc<=target+4, where target={branch_target[ADDR_W-1:2],2'b00}.
  - The word captured on this same edge is the delay-slot instruction at the old pc. Delayed-branch semantics therefore need no extra bubble.
- IF/ID capture (stall=0): ifid_pc<=pc.
  - annul=0: ifid_instr<=rom_instr, ifid_valid<=1, fetch_count<=fetch_count+1.
  - annul=1: ifid_instr<=NOP_WORD, ifid_valid<=0, fetch_count holds.
  - annul is independent of branch_taken. Decode asserts it for ba,a (taken) and for untaken conditional branches with a=1.
- Arithmetic: pc/npc increments are modulo 2^ADDR_W. 0x1FC+4 wraps to 0x000 with no error flag. fetch_count wraps modulo 2^32.
- pc[1:0] is always 00. Misaligned targets are silently aligned.
- First edge after reset release captures the word at RESET_PC with ifid_valid=1.

Decomposition:
- Shared package (sparc_pkg) holds ADDR_W, NOP_WORD and the instruction-word width constant (32), shared with the ROM and decode.
- No sub-module needed: the PC/nPC logic and the IF/ID register are a single always block plus the next-state logic.
- Optional sub-module: sparc_ifid_reg (IF/ID register with hold and squash), reusable for later pipeline registers.

Test Plan:
- Reset, then 4 free-running cycles with ROM bytes 0..15 = 0x00..0x0F:
  - ifid_pc = 0,4,8,C.
  - ifid_instr = 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F.
  - ifid_valid=1; fetch_count=4.
- stall=1 for 3 cycles at pc=8 -> rom_addr stays 8; ifid_pc stays 4; fetch_count unchanged; fetch resumes at 8 after stall drops.
- branch_taken=1 with branch_target=0x40 when pc=0x0C:
  - next ifid_pc=0x0C (delay slot, valid=1).
  - then ifid_pc=0x40, then 0x44.
- branch_taken=1 and annul=1 with branch_target=0x83 when pc=0x20:
  - ifid_valid=0 and ifid_instr=0x01000000 for the 0x20 slot.
  - then ifid_pc=0x80 (aligned).
  - fetch_count does not increment for the annulled slot.
- Wrap: run from pc=0x1F8 -> rom_addr 0x1F8, 0x1FC, 0x000, 0x004.
- rst_n=0 asserted during stall=1 and branch_taken=1 -> next edge pc=0, ifid_valid=0, ifid_instr=0x01000000, fetch_count=0.
